// File: rtl/pixel_scan_gen.sv
// pixel_scan_gen: raster scan source for the ray-trace core.
// Walks x = 0..H_RES-1 within y = 0..V_RES-1 and offers one pixel per valid/ready transfer.
// A linear framebuffer address is kept in step with each pixel.
//
// Ports:
//   clk, rstn      clock; asynchronous active-low reset
//   start          begin a frame (honoured in IDLE only)
//   abort          synchronous frame cancel (RUN/DONE)
//   pix_ready      downstream accepts the current pixel
//   pix_valid      pixel_x/y/z and pix_addr are valid
//   pixel_x/y/z    current pixel; z is the constant Z_PLANE
//   pix_addr       pixel_y*H_RES + pixel_x
//   pix_last       current pixel is the final one of the frame
//   busy           frame in progress (RUN or DONE)
//   frame_done     one-cycle pulse after the last pixel is accepted
//   frame_cnt      completed-frame counter, wraps
module pixel_scan_gen #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9,
    parameter int unsigned Z_W     = 5,
    parameter int unsigned Z_PLANE = 31,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned LOOP    = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_ready,
    output logic              pix_valid,
    output logic [X_W-1:0]    pixel_x,
    output logic [Y_W-1:0]    pixel_y,
    output logic [Z_W-1:0]    pixel_z,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_last,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [X_W-1:0] XMax = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] YMax = Y_W'(V_RES - 1);

    state_e              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic x_end, y_end;

    assign x_end = (x_q == XMax);
    assign y_end = (y_q == YMax);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    // Cancel takes priority over a transfer on the same edge.
                    state_d = StIdle;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end else if (pix_ready) begin
                    if (x_end && y_end) begin
                        state_d = StDone;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                    end else if (x_end) begin
                        x_d    = '0;
                        y_d    = y_q + Y_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        x_d    = x_q + X_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            StDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    // Count lands together with leaving DONE so an abort here leaves it untouched.
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = (LOOP != 0) ? StRun : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pix_valid  = (state_q == StRun);
    assign pixel_x    = x_q;
    assign pixel_y    = y_q;
    assign pixel_z    = Z_W'(Z_PLANE);
    assign pix_addr   = addr_q;
    assign pix_last   = pix_valid && x_end && y_end;
    assign busy       = (state_q != StIdle);
    // Suppressed when an abort lands in the DONE cycle.
    assign frame_done = (state_q == StDone) && !abort;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pixel_scan_gen.sv
module tb_pixel_scan_gen;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A: default 640x480, B: 4x3 single frame, C: 4x3 looping
    logic a_start, a_abort, a_ready, a_valid, a_last, a_busy, a_fd;
    logic [9:0]  a_x;
    logic [8:0]  a_y;
    logic [4:0]  a_z;
    logic [18:0] a_addr;
    logic [15:0] a_cnt;

    logic b_start, b_abort, b_ready, b_valid, b_last, b_busy, b_fd;
    logic [9:0]  b_x;
    logic [8:0]  b_y;
    logic [4:0]  b_z;
    logic [18:0] b_addr;
    logic [15:0] b_cnt;

    logic c_start, c_abort, c_ready, c_valid, c_last, c_busy, c_fd;
    logic [9:0]  c_x;
    logic [8:0]  c_y;
    logic [4:0]  c_z;
    logic [18:0] c_addr;
    logic [15:0] c_cnt;

    pixel_scan_gen u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .abort(a_abort), .pix_ready(a_ready),
        .pix_valid(a_valid), .pixel_x(a_x), .pixel_y(a_y), .pixel_z(a_z), .pix_addr(a_addr),
        .pix_last(a_last), .busy(a_busy), .frame_done(a_fd), .frame_cnt(a_cnt)
    );

    pixel_scan_gen #(.H_RES(4), .V_RES(3)) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .abort(b_abort), .pix_ready(b_ready),
        .pix_valid(b_valid), .pixel_x(b_x), .pixel_y(b_y), .pixel_z(b_z), .pix_addr(b_addr),
        .pix_last(b_last), .busy(b_busy), .frame_done(b_fd), .frame_cnt(b_cnt)
    );

    pixel_scan_gen #(.H_RES(4), .V_RES(3), .LOOP(1)) u_c (
        .clk(clk), .rstn(rstn), .start(c_start), .abort(c_abort), .pix_ready(c_ready),
        .pix_valid(c_valid), .pixel_x(c_x), .pixel_y(c_y), .pixel_z(c_z), .pix_addr(c_addr),
        .pix_last(c_last), .busy(c_busy), .frame_done(c_fd), .frame_cnt(c_cnt)
    );

    // Expected view of B when showing pixel index k of the 4x3 raster.
    task automatic check_b_pix(input string tag, input int k);
        check({tag, "_valid"}, 32'(b_valid), 32'd1);
        check({tag, "_x"}, 32'(b_x), 32'(k % 4));
        check({tag, "_y"}, 32'(b_y), 32'(k / 4));
        check({tag, "_addr"}, 32'(b_addr), 32'(k));
        check({tag, "_last"}, 32'(b_last), 32'(k == 11));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] pat;
        int k;
        int cyc;

        rstn = 1'b0;
        {a_start, a_abort, a_ready} = '0;
        {b_start, b_abort, b_ready} = '0;
        {c_start, c_abort, c_ready} = '0;
        #1;
        check("rst_valid", 32'(b_valid), 32'd0);
        check("rst_busy", 32'(b_busy), 32'd0);
        check("rst_fd", 32'(b_fd), 32'd0);
        check("rst_x", 32'(b_x), 32'd0);
        check("rst_y", 32'(b_y), 32'd0);
        check("rst_addr", 32'(b_addr), 32'd0);
        check("rst_cnt", 32'(b_cnt), 32'd0);
        check("rst_z", 32'(b_z), 32'd31);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Single frame, no stalls
        b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_b_pix("f1", i);
            if (i == 7) check("f1_z", 32'(b_z), 32'd31);
            @(negedge clk);
        end
        check("f1_end_valid", 32'(b_valid), 32'd0);
        check("f1_end_fd", 32'(b_fd), 32'd1);
        check("f1_end_busy", 32'(b_busy), 32'd1);
        @(negedge clk);
        check("f1_post_fd", 32'(b_fd), 32'd0);
        check("f1_post_busy", 32'(b_busy), 32'd0);
        check("f1_post_cnt", 32'(b_cnt), 32'd1);

        // Backpressure: outputs must track the model index, which only moves on a transfer
        pat = 16'b1011_0010_1100_1101;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 12 && cyc < 200) begin
            b_ready = pat[cyc % 16];
            check_b_pix("bp", k);
            if (b_ready) k++;
            cyc++;
            @(negedge clk);
        end
        check("bp_count", 32'(k), 32'd12);
        check("bp_fd", 32'(b_fd), 32'd1);
        check("bp_end_valid", 32'(b_valid), 32'd0);
        @(negedge clk);
        check("bp_cnt", 32'(b_cnt), 32'd2);

        // Abort at (2,1) while stalled
        b_ready = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (6) @(negedge clk);
        b_ready = 1'b0;
        check_b_pix("ab_pre", 6);
        @(negedge clk);
        check_b_pix("ab_hold", 6);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        check("ab_valid", 32'(b_valid), 32'd0);
        check("ab_busy", 32'(b_busy), 32'd0);
        check("ab_fd", 32'(b_fd), 32'd0);
        check("ab_x", 32'(b_x), 32'd0);
        check("ab_addr", 32'(b_addr), 32'd0);
        @(negedge clk);
        check("ab_fd2", 32'(b_fd), 32'd0);
        check("ab_cnt", 32'(b_cnt), 32'd2);
        b_ready = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check_b_pix("ab_restart", 0);
        repeat (3) @(negedge clk);
        b_ready = 1'b0;

        // LOOP=1: three back-to-back frames, stray start pulses mid-frame
        c_ready = 1'b1;
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            for (int i = 0; i < 12; i++) begin
                check("lp_valid", 32'(c_valid), 32'd1);
                check("lp_x", 32'(c_x), 32'(i % 4));
                check("lp_y", 32'(c_y), 32'(i / 4));
                c_start = (i == 5);
                @(negedge clk);
            end
            c_start = 1'b0;
            check("lp_gap_valid", 32'(c_valid), 32'd0);
            check("lp_gap_fd", 32'(c_fd), 32'd1);
            @(negedge clk);
            check("lp_cnt", 32'(c_cnt), 32'(f));
        end
        c_abort = 1'b1;
        @(negedge clk);
        c_abort = 1'b0;
        check("lp_stop_valid", 32'(c_valid), 32'd0);
        check("lp_stop_cnt", 32'(c_cnt), 32'd3);

        // Line wrap at 640 pixels per line
        a_ready = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (639) @(negedge clk);
        check("wr_x_end", 32'(a_x), 32'd639);
        check("wr_y0", 32'(a_y), 32'd0);
        check("wr_addr_end", 32'(a_addr), 32'd639);
        check("wr_last0", 32'(a_last), 32'd0);
        @(negedge clk);
        check("wr_valid", 32'(a_valid), 32'd1);
        check("wr_x0", 32'(a_x), 32'd0);
        check("wr_y1", 32'(a_y), 32'd1);
        check("wr_addr", 32'(a_addr), 32'd640);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        check("wr_abort_valid", 32'(a_valid), 32'd0);

        // Asynchronous reset mid-frame: B is stalled on pixel 3
        check("ar_pre_x", 32'(b_x), 32'd3);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("ar_valid", 32'(b_valid), 32'd0);
        check("ar_busy", 32'(b_busy), 32'd0);
        check("ar_x", 32'(b_x), 32'd0);
        check("ar_addr", 32'(b_addr), 32'd0);
        check("ar_cnt", 32'(b_cnt), 32'd0);
        check("ar_c_cnt", 32'(c_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
